// File: rtl/sd_dat_rx_pkg.sv
// Shared constants, state encoding and CRC16 step for the SD DAT0 block receiver.
package sd_dat_rx_pkg;

    localparam logic [15:0]  CRC16_POLY      = 16'h1021;
    localparam int unsigned  BLOCK_BYTES_DEF = 512;
    localparam int unsigned  TIMEOUT_CE_DEF  = 65535;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SB,
        ST_DATA,
        ST_CRC,
        ST_END
    } state_t;

    typedef struct packed {
        logic crc_err;
        logic end_err;
        logic tout;
    } rx_status_t;

    // One serial CCITT step, MSB-first feed.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        crc16_step = {crc[14:0], 1'b0} ^ (((crc[15] ^ din) == 1'b1) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_dat_rx_if.sv
// Sample-side inputs and block/byte results of the DAT0 receiver.
interface sd_dat_rx_if;
    logic       ce;
    logic       start;
    logic       dat;
    logic [7:0] data;
    logic       val;
    logic       busy;
    logic       done;
    logic       crc_err;
    logic       end_err;
    logic       tout;

    modport master (output ce, start, dat,
                    input  data, val, busy, done, crc_err, end_err, tout);
    modport slave  (input  ce, start, dat,
                    output data, val, busy, done, crc_err, end_err, tout);
endinterface

// File: rtl/sd_dat_rx_crc16_chk.sv
// Serial CRC16 checker register; a clean data+CRC stream leaves zero residue.
module sd_dat_rx_crc16_chk
    import sd_dat_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc16_step(crc, din);
        end
    end

endmodule

// File: rtl/sd_dat_rx.sv
// SD DAT0 single-block receiver: start-bit hunt, byte deserialiser, CRC16 and end-bit check.
module sd_dat_rx
    import sd_dat_rx_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES = BLOCK_BYTES_DEF,
    parameter int unsigned TIMEOUT_CE  = TIMEOUT_CE_DEF
)(
    input  logic           clk,
    input  logic           rst,
    sd_dat_rx_if.slave     bus
);

    localparam int unsigned BW = $clog2(BLOCK_BYTES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CE + 1);

    state_t            state, state_n;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [BW-1:0]     byte_cnt, byte_cnt_n;
    logic [TW-1:0]     tcnt, tcnt_n;
    logic [7:0]        shreg, shreg_n;
    logic [7:0]        data_q, data_n;
    logic [7:0]        byte_next;
    logic              val_q, val_n;
    logic              done_q, done_n;
    logic              busy_q, busy_n;
    rx_status_t        sts, sts_n;
    logic              crc_clr;
    logic              crc_en;
    logic [15:0]       crc;

    sd_dat_rx_crc16_chk u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (bus.dat),
        .crc (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tcnt     <= '0;
            shreg    <= '0;
            data_q   <= '0;
            val_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            sts      <= '0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            byte_cnt <= byte_cnt_n;
            tcnt     <= tcnt_n;
            shreg    <= shreg_n;
            data_q   <= data_n;
            val_q    <= val_n;
            done_q   <= done_n;
            busy_q   <= busy_n;
            sts      <= sts_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        tcnt_n     = tcnt;
        shreg_n    = shreg;
        data_n     = data_q;
        val_n      = 1'b0;
        done_n     = 1'b0;
        sts_n      = sts;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        byte_next  = {shreg[6:0], bus.dat};

        unique case (state)
            ST_IDLE: begin
                // A CE coinciding with START is deliberately not sampled.
                if (bus.start) begin
                    state_n    = ST_WAIT_SB;
                    bit_cnt_n  = '0;
                    byte_cnt_n = '0;
                    tcnt_n     = '0;
                    sts_n      = '0;
                    crc_clr    = 1'b1;
                end
            end
            ST_WAIT_SB: begin
                if (bus.ce) begin
                    if (!bus.dat) begin
                        state_n = ST_DATA;
                    end else if (tcnt == TW'(TIMEOUT_CE - 1)) begin
                        sts_n.tout = 1'b1;
                        done_n     = 1'b1;
                        state_n    = ST_IDLE;
                    end else begin
                        tcnt_n = tcnt + TW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (bus.ce) begin
                    crc_en  = 1'b1;
                    shreg_n = byte_next;
                    if (bit_cnt[2:0] == 3'd7) begin
                        data_n    = byte_next;
                        val_n     = 1'b1;
                        bit_cnt_n = '0;
                        if (byte_cnt == BW'(BLOCK_BYTES - 1)) begin
                            byte_cnt_n = '0;
                            state_n    = ST_CRC;
                        end else begin
                            byte_cnt_n = byte_cnt + BW'(1);
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
            end
            ST_CRC: begin
                if (bus.ce) begin
                    crc_en = 1'b1;
                    if (bit_cnt == 4'd15) begin
                        bit_cnt_n = '0;
                        state_n   = ST_END;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
            end
            ST_END: begin
                if (bus.ce) begin
                    sts_n.end_err = ~bus.dat;
                    sts_n.crc_err = (crc != 16'h0000);
                    done_n        = 1'b1;
                    state_n       = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    assign bus.data    = data_q;
    assign bus.val     = val_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.crc_err = sts.crc_err;
    assign bus.end_err = sts.end_err;
    assign bus.tout    = sts.tout;

endmodule

// File: tb/tb_sd_dat_rx.sv
// Scoreboard bench for sd_dat_rx: bytes and block status queued at drive time, checked on O_VAL/DONE.
module tb_sd_dat_rx;

    localparam int BLOCK   = 512;
    localparam int TOUT_CE = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sd_dat_rx_if bus ();

    sd_dat_rx #(.BLOCK_BYTES(BLOCK), .TIMEOUT_CE(TOUT_CE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    int         ce_gap   = 0;
    logic [7:0] exp_q[$];
    logic [2:0] st_q[$];
    logic [7:0] blk[BLOCK];
    logic [7:0] mon_byte;
    logic [2:0] mon_sts;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: every O_VAL/DONE must match a queued expectation.
    always @(negedge clk) begin
        if (bus.val === 1'b1) begin
            check("val_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_byte = exp_q.pop_front();
                check("rx_byte", 32'(bus.data), 32'(mon_byte));
            end
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            check("done_expected", 32'(st_q.size() > 0), 32'd1);
            if (st_q.size() > 0) begin
                mon_sts = st_q.pop_front();
                check("crc_err", 32'(bus.crc_err), 32'(mon_sts[2]));
                check("end_err", 32'(bus.end_err), 32'(mon_sts[1]));
                check("tout",    32'(bus.tout),    32'(mon_sts[0]));
            end
        end
    end

    task automatic drive_bit(input logic b);
        bus.dat = b;
        bus.ce  = 1'b1;
        @(posedge clk); #1;
        bus.ce  = 1'b0;
        repeat (ce_gap) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start(input logic with_ce);
        bus.start = 1'b1;
        bus.ce    = with_ce;
        bus.dat   = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.ce    = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        for (int i = 0; i < 20 && done_cnt == d0; i++) @(posedge clk);
        #1;
        check(tag, 32'(done_cnt - d0), 32'd1);
    endtask

    function automatic logic [15:0] crc_of_block();
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        for (int k = 0; k < BLOCK; k++)
            for (int j = 7; j >= 0; j--) begin
                fb = c[15] ^ blk[k][j];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        return c;
    endfunction

    task automatic send_block(input logic [15:0] crc, input logic endb, input int pre,
                              input int mid_start, input logic start_ce, input logic [2:0] sts);
        int d0;
        pulse_start(start_ce);
        for (int i = 0; i < pre; i++) drive_bit(1'b1);
        drive_bit(1'b0);
        for (int k = 0; k < BLOCK; k++) begin
            if (k == mid_start) begin
                check("busy_mid", 32'(bus.busy), 32'd1);
                pulse_start(1'b0);
            end
            exp_q.push_back(blk[k]);
            for (int j = 7; j >= 0; j--) drive_bit(blk[k][j]);
        end
        for (int j = 15; j >= 0; j--) drive_bit(crc[j]);
        st_q.push_back(sts);
        d0 = done_cnt;
        drive_bit(endb);
        wait_done(d0, "block_done");
        check("bytes_left", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("busy_after", 32'(bus.busy), 32'd0);
        check("crc_err_hold", 32'(bus.crc_err), 32'(sts[2]));
        check("end_err_hold", 32'(bus.end_err), 32'(sts[1]));
    endtask

    task automatic fill_ff();
        for (int k = 0; k < BLOCK; k++) blk[k] = 8'hFF;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int d0;
        bus.ce = 1'b0; bus.start = 1'b0; bus.dat = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_val",  32'(bus.val),  32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_data", 32'(bus.data), 32'd0);
        check("rst_flags", 32'({bus.crc_err, bus.end_err, bus.tout}), 32'd0);

        // Good all-0xFF block, back-to-back CE.
        fill_ff();
        ce_gap = 0;
        send_block(16'h7FA1, 1'b1, 3, -1, 1'b0, 3'b000);
        // CRC LSB flipped.
        send_block(16'h7FA0, 1'b1, 0, -1, 1'b0, 3'b100);
        // Bad end bit.
        send_block(16'h7FA1, 1'b0, 1, -1, 1'b0, 3'b010);

        // Start-bit timeout after exactly TOUT_CE samples of DAT=1.
        pulse_start(1'b0);
        d0 = done_cnt;
        for (int i = 0; i < TOUT_CE - 1; i++) drive_bit(1'b1);
        check("tout_early_busy", 32'(bus.busy), 32'd1);
        check("tout_early_done", 32'(done_cnt - d0), 32'd0);
        st_q.push_back(3'b001);
        drive_bit(1'b1);
        check("tout_done_now", 32'(bus.done), 32'd1);
        wait_done(d0, "tout_done");
        check("tout_hold", 32'(bus.tout), 32'd1);

        // Sparse CE, ignored mid-block START, 9 idle ones before the start bit.
        ce_gap = 2;
        send_block(16'h7FA1, 1'b1, TOUT_CE - 1, 200, 1'b0, 3'b000);
        ce_gap = 0;

        // Reset after byte 100 aborts, then a full block still works.
        pulse_start(1'b0);
        drive_bit(1'b0);
        for (int k = 0; k <= 100; k++) begin
            exp_q.push_back(blk[k]);
            for (int j = 7; j >= 0; j--) drive_bit(blk[k][j]);
        end
        d0 = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_data", 32'(bus.data), 32'd0);
        check("abort_val",  32'(bus.val),  32'd0);
        repeat (20) drive_bit(1'b0);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_bytes", 32'(exp_q.size()), 32'd0);
        send_block(16'h7FA1, 1'b1, 2, -1, 1'b0, 3'b000);

        // Random payload; a CE with DAT=0 alongside START must not count as the start bit.
        for (int k = 0; k < BLOCK; k++) blk[k] = 8'($urandom);
        send_block(crc_of_block(), 1'b1, 0, -1, 1'b1, 3'b000);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
